shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle 32-bit barrel shifter that applies the 16/8/4/2/1 shift stages one per clock.
//  It sits between the register-file read stage and the writeback stage.
//  Each operand enters through a valid/ready handshake. Stages run MSB-first on SH_AMT.
//  The result is held on D_OUT with OUT_VALID until downstream takes it.
//  Right shifts are arithmetic (sign fill); left shifts fill with zeros.
// PARAMETERS
//  DATA_W  32  operand width; must equal 2**AMT_W
//  AMT_W   5   shift-amount width; also the number of stage cycles
// PORTS
//  CLK        in   1       clock; all state updates on rising edge
//  RST        in   1       synchronous, active-high reset
//  IN_VALID   in   1       operand present on SH_DIR/SH_AMT/D_IN
//  IN_READY   out  1       block can accept an operand (IDLE only)
//  SH_DIR     in   1       1 = arithmetic shift right, 0 = logical shift left
//  SH_AMT     in   AMT_W   shift amount, 0..DATA_W-1
//  D_IN       in   DATA_W  operand
//  OUT_VALID  out  1       D_OUT holds a finished result
//  OUT_READY  in   1       downstream accepts the result
//  D_OUT      out  DATA_W  result register
// BEHAVIOUR
//  States: IDLE, SHIFT, DONE. Stage index STG runs AMT_W-1 down to 0.
//  Reset (RST=1 at an edge, from any state, including mid-SHIFT):
//  - state=IDLE, D_OUT=0, OUT_VALID=0, internal dir/amt regs=0.
//  - IN_READY=0 while RST is high; inputs are ignored.
//  IDLE:
//  - IN_READY=1.
//  - On an edge with IN_VALID=1: D_OUT<=D_IN, latch SH_DIR and SH_AMT, STG<=AMT_W-1, go to SHIFT.
//  SHIFT:
//  - IN_READY=0; IN_VALID is ignored.
//  - Each edge: if amt[STG]=1, D_OUT shifts by 2**STG; otherwise D_OUT is unchanged.
//  - Right shift fills the top 2**STG bits with the current D_OUT[DATA_W-1].
//  - Left shift fills the low 2**STG bits with 0.
//  - STG decrements each edge. After the edge that processes STG=0: go to DONE, OUT_VALID<=1.
//  Latency: OUT_VALID rises exactly AMT_W (=5) edges after the accept edge.
//  - Fixed for every SH_AMT, including 0.
//  DONE:
//  - OUT_VALID=1. D_OUT is held stable. IN_READY=0.
//  - On an edge with OUT_READY=1: OUT_VALID<=0, go to IDLE.
//  - A new operand is accepted no earlier than the following edge.
//  Throughput: at most one operation per AMT_W+2 cycles. No overlap of operations.
//  Width rules: D_OUT never changes width; there is no carry-out or overflow flag.
//  - Bits shifted out are discarded.
//  Boundaries:
//  - SH_AMT=0 -> D_OUT=D_IN.
//  - SH_AMT=31, right shift, negative operand -> 0xFFFF_FFFF.
//  - SH_AMT=31, right shift, positive operand -> 0.
//  - OUT_READY held high early has no effect before DONE.
// TESTING
//  1. D_IN=0x8000_0000, DIR=1, AMT=8 -> D_OUT=0xFF80_0000; OUT_VALID 5 edges after accept.
//  2. D_IN=0x1234_5678, DIR=1, AMT=13 -> 0x0000_91A2.
//     Same operand with DIR=0, AMT=4 -> 0x2345_6780.
//  3. D_IN=0x0000_00FF, DIR=0, AMT=31 -> 0x8000_0000.
//     D_IN=0x7FFF_FFFF, DIR=1, AMT=31 -> 0x0000_0000.
//  4. AMT=0, D_IN=0xDEAD_BEEF -> D_OUT=0xDEAD_BEEF after 5 edges (latency unchanged).
//  5. Backpressure: OUT_READY=0 for 3 cycles in DONE, IN_VALID=1 throughout.
//     -> D_OUT stable, OUT_VALID=1, IN_READY=0, no second accept.
//     -> OUT_READY=1 returns to IDLE.
//  6. RST=1 for one edge during the 2nd SHIFT cycle.
//     -> next cycle: OUT_VALID=0, D_OUT=0, IN_READY=1; no stale result ever appears.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one power-of-two stage per clock, MSB stage first; arithmetic right / logical left.
// Latency: OUT_VALID rises exactly AMT_W edges after the accept edge, for every shift amount.
// Backpressure: result held in DONE until OUT_READY; IN_READY only in IDLE, so operations never overlap.
module shift_sequencer #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              SH_DIR,
    input  logic [AMT_W-1:0]  SH_AMT,
    input  logic [DATA_W-1:0] D_IN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] D_OUT
);

    localparam int STG_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic              dir_q, dir_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] stage_val;

    // Each stage index selects one fixed-distance shift; skipped when its amount bit is clear.
    always_comb begin
        stage_val = d_out_q;
        for (int i = 0; i < AMT_W; i++) begin
            if ((stg_q == STG_W'(i)) && amt_q[i]) begin
                if (dir_q) begin
                    stage_val = DATA_W'($signed(d_out_q) >>> (1 << i));
                end else begin
                    stage_val = d_out_q << (1 << i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stg_d       = stg_q;
        dir_d       = dir_q;
        amt_d       = amt_q;
        d_out_d     = d_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    d_out_d = D_IN;
                    dir_d   = SH_DIR;
                    amt_d   = SH_AMT;
                    stg_d   = STG_W'(AMT_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                d_out_d = stage_val;
                if (stg_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    stg_d = stg_q - 1'b1;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            stg_q       <= '0;
            dir_q       <= 1'b0;
            amt_q       <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg_q       <= stg_d;
            dir_q       <= dir_d;
            amt_q       <= amt_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = (state_q == IDLE) && !RST;
    assign OUT_VALID = out_valid_q;
    assign D_OUT     = d_out_q;

endmodule
